// File: rtl/apb_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// apb_irq_ctrl_if
// AHB-lite slave bus bundle for the interrupt controller register port.
//   HSEL, HADDR[7:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HREADY, HWDATA[31:0]
//     : driven by the bus master (address phase / data phase)
//   HREADYOUT, HRDATA[31:0], HRESP
//     : driven by the slave (zero wait state, always OKAY)
// ---------------------------------------------------------------------------
interface apb_irq_ctrl_if;
  logic        HSEL;
  logic [7:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/apb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// apb_irq_ctrl
// Interrupt controller for the APB peripheral interrupt vector. Sources are
// synchronised into HCLK, latched as rising-edge or level events, masked,
// prioritised (index 0 highest) and presented as one registered CPU request
// with a 5-bit source ID. Registers are reached over an AHB-lite slave port.
//
// Ports:
//   HCLK        system clock
//   HRESET      asynchronous active-high reset
//   bus         AHB-lite slave bundle (apb_irq_ctrl_if.slave)
//   irq_src     raw interrupt vector, asynchronous to HCLK
//   irq_o       CPU interrupt request (registered)
//   irq_id      index of the highest-priority active source (registered)
//
// Register map (word offsets):
//   0x00 PENDING R/W1C, 0x04 ENABLE RW, 0x08 EDGE RW (1 = rising edge),
//   0x0C CLAIM RO, 0x10 RAW RO; all other offsets read 0.
//
// Build option: define APB_IRQ_CTRL_CLAIM_CLEAR_EN to make a CLAIM read
// while irq_o=1 clear the claimed edge-mode source's PENDING bit.
// ---------------------------------------------------------------------------
module apb_irq_ctrl #(
  parameter int NUM_SRC     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               HCLK,
  input  logic               HRESET,
  apb_irq_ctrl_if.slave      bus,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq_o,
  output logic [4:0]         irq_id
);

  localparam logic [31:0] SRC_MASK =
    (NUM_SRC >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NUM_SRC) - 32'd1);

  localparam logic [5:0] A_PENDING = 6'h00;
  localparam logic [5:0] A_ENABLE  = 6'h01;
  localparam logic [5:0] A_EDGE    = 6'h02;
  localparam logic [5:0] A_CLAIM   = 6'h03;
  localparam logic [5:0] A_RAW     = 6'h04;

  // Synchroniser chain: stage 0 samples the pins, the last stage is s.
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_reg;
  logic [31:0] s_w;
  logic [31:0] s_d_reg;

  // Register state, kept 32 bits wide with bits >= NUM_SRC tied low.
  logic [31:0] pend_reg;
  logic [31:0] enable_reg;
  logic [31:0] edge_reg;
  logic [31:0] pend_next;
  logic [31:0] pending;
  logic [31:0] act;
  logic [31:0] rise;
  logic [31:0] w1c;
  logic [31:0] claim_clr;

  logic        irq_o_reg;
  logic [4:0]  irq_id_reg;
  logic [4:0]  irq_id_next;

  // Captured address phase.
  logic        dp_valid_reg;
  logic        dp_write_reg;
  logic [5:0]  dp_addr_reg;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rdata;

  logic        unused_bus_bits;
  assign unused_bus_bits = ^{bus.HSIZE, bus.HADDR[1:0], bus.HTRANS[0]};

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sync_reg <= '0;
      s_d_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_src};
      s_d_reg  <= s_w;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_ext
      if (gi < NUM_SRC) begin : g_src
        assign s_w[gi] = sync_reg[SYNC_STAGES-1][gi];
      end else begin : g_pad
        assign s_w[gi] = 1'b0;
      end
    end
  endgenerate

  assign wr_en = dp_valid_reg & dp_write_reg;
  assign rd_en = dp_valid_reg & ~dp_write_reg;
  assign rise  = s_w & ~s_d_reg;
  assign w1c   = (wr_en && dp_addr_reg == A_PENDING) ? (bus.HWDATA & SRC_MASK) : 32'd0;

`ifdef APB_IRQ_CTRL_CLAIM_CLEAR_EN
  // The ID being returned by this CLAIM read is the one cleared.
  assign claim_clr = (rd_en && dp_addr_reg == A_CLAIM && irq_o_reg) ?
                     ((32'd1 << irq_id_reg) & SRC_MASK) : 32'd0;
`else
  assign claim_clr = 32'd0;
`endif

  // Level-mode bits follow s directly; pend_reg still tracks s for them so
  // a switch to edge mode keeps the value software last saw.
  assign pending = (pend_reg & edge_reg) | (s_w & ~edge_reg);
  assign act     = pending & enable_reg;

  always_comb begin
    // Edge mode: a new edge beats a same-cycle clear.
    pend_next = (((pend_reg & ~(w1c | claim_clr)) | rise) & edge_reg)
              | (s_w & ~edge_reg);
    pend_next = pend_next & SRC_MASK;
  end

  // Lowest set index wins; scan downward so the last hit is the lowest.
  always_comb begin
    irq_id_next = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (act[i]) irq_id_next = i[4:0];
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend_reg   <= '0;
      enable_reg <= '0;
      edge_reg   <= '0;
      irq_o_reg  <= 1'b0;
      irq_id_reg <= 5'd0;
    end else begin
      pend_reg   <= pend_next;
      irq_o_reg  <= |act;
      irq_id_reg <= irq_id_next;
      if (wr_en && dp_addr_reg == A_ENABLE) enable_reg <= bus.HWDATA & SRC_MASK;
      if (wr_en && dp_addr_reg == A_EDGE)   edge_reg   <= bus.HWDATA & SRC_MASK;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_addr_reg  <= 6'd0;
    end else begin
      dp_valid_reg <= bus.HSEL & bus.HREADY & bus.HTRANS[1];
      dp_write_reg <= bus.HWRITE;
      dp_addr_reg  <= bus.HADDR[7:2];
    end
  end

  // Read data is a live view of register state during the data phase, so a
  // read right after a write already sees the written value.
  always_comb begin
    rdata = 32'd0;
    if (rd_en) begin
      case (dp_addr_reg)
        A_PENDING: rdata = pending;
        A_ENABLE:  rdata = enable_reg;
        A_EDGE:    rdata = edge_reg;
        A_CLAIM:   rdata = irq_o_reg ? {27'd0, irq_id_reg} : 32'h0000_0020;
        A_RAW:     rdata = s_w;
        default:   rdata = 32'd0;
      endcase
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign irq_o         = irq_o_reg;
  assign irq_id        = irq_id_reg;

endmodule
